// File: rtl/register_file_pkg.sv
// register_file_pkg
//   Shared core constants for the architectural register file.
//   REGISTER_WIDTH : default bit width of each register and data bus.
//   REGISTER_DEPTH : default number of architectural registers.
//   reg_addr_t     : register index type for the default depth.
package register_file_pkg;

    localparam int REGISTER_WIDTH = 32;
    localparam int REGISTER_DEPTH = 32;

    typedef logic [$clog2(REGISTER_DEPTH)-1:0] reg_addr_t;

endpackage

// File: rtl/register_file_read_port.sv
// register_file_read_port
//   One synchronous read port of the register file: registered read mux
//   plus a valid flag, with one cycle of latency from address presentation.
//   Optional macro REGFILE_WRITE_BYPASS_EN adds a write-to-read bypass so a
//   read that collides with a same-cycle write returns the new data.
//
// Ports
//   clk, rst       : clock, asynchronous active-high reset
//   read_enable    : sample the port this cycle
//   read_address   : register index to read
//   storage        : current contents of all registers
//   write_enable/write_address/write_data : write port (only with the macro)
//   read_data      : registered read result, held while idle
//   read_valid     : read_data holds a result sampled last cycle
module register_file_read_port
    import register_file_pkg::*;
#(
    parameter int WIDTH = REGISTER_WIDTH,
    parameter int DEPTH = REGISTER_DEPTH
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            read_enable,
    input  logic [$clog2(DEPTH)-1:0]        read_address,
    input  logic [DEPTH-1:0][WIDTH-1:0]     storage,
`ifdef REGFILE_WRITE_BYPASS_EN
    input  logic                            write_enable,
    input  logic [$clog2(DEPTH)-1:0]        write_address,
    input  logic [WIDTH-1:0]                write_data,
`endif
    output logic [WIDTH-1:0]                read_data,
    output logic                            read_valid
);

    logic [WIDTH-1:0] read_data_d, read_data_q;
    logic             read_valid_d, read_valid_q;
    logic [WIDTH-1:0] mux_data;
    logic             addr_live;

    always_comb begin
        // Address 0 and out-of-range indices (non-power-of-2 DEPTH) read as 0.
        addr_live = (read_address != '0) && (32'(read_address) < 32'(DEPTH));
        mux_data  = '0;
        if (addr_live) begin
            mux_data = storage[read_address];
        end
`ifdef REGFILE_WRITE_BYPASS_EN
        if (addr_live && write_enable && (write_address == read_address)) begin
            mux_data = write_data;
        end
`endif
        read_data_d  = read_enable ? mux_data : read_data_q;
        read_valid_d = read_enable;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            read_data_q  <= '0;
            read_valid_q <= 1'b0;
        end else begin
            read_data_q  <= read_data_d;
            read_valid_q <= read_valid_d;
        end
    end

    assign read_data  = read_data_q;
    assign read_valid = read_valid_q;

endmodule

// File: rtl/register_file.sv
// register_file
//   DEPTH x WIDTH architectural register file with one write port and two
//   synchronous read ports (1-cycle latency). Register x0 is hardwired to 0.
//   Optional macro REGFILE_WRITE_BYPASS_EN: a read colliding with a
//   same-cycle write to the same nonzero register returns the new data;
//   without it the read returns the old value (decode must forward).
//
// Ports
//   clk, rst                    : clock, asynchronous active-high reset
//   registerport_write_enable   : write strobe, always accepted
//   registerport_write_address  : destination register
//   registerport_write_data     : write data
//   read_enable_a/b             : sample read port this cycle
//   read_address_a/b            : register index for the port
//   read_data_a/b               : registered read result
//   read_valid_a/b              : result of a read sampled last cycle
module register_file
    import register_file_pkg::*;
#(
    parameter int WIDTH = REGISTER_WIDTH,
    parameter int DEPTH = REGISTER_DEPTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      registerport_write_enable,
    input  logic [$clog2(DEPTH)-1:0]  registerport_write_address,
    input  logic [WIDTH-1:0]          registerport_write_data,
    input  logic                      read_enable_a,
    input  logic [$clog2(DEPTH)-1:0]  read_address_a,
    output logic [WIDTH-1:0]          read_data_a,
    output logic                      read_valid_a,
    input  logic                      read_enable_b,
    input  logic [$clog2(DEPTH)-1:0]  read_address_b,
    output logic [WIDTH-1:0]          read_data_b,
    output logic                      read_valid_b
);

    logic [DEPTH-1:0][WIDTH-1:0] storage_d, storage_q;
    logic                        write_commit;

    always_comb begin
        // Writes to x0 or beyond DEPTH are dropped, so x0 never leaves 0.
        write_commit = registerport_write_enable
                    && (registerport_write_address != '0)
                    && (32'(registerport_write_address) < 32'(DEPTH));
        storage_d = storage_q;
        if (write_commit) begin
            storage_d[registerport_write_address] = registerport_write_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            storage_q <= '0;
        end else begin
            storage_q <= storage_d;
        end
    end

    register_file_read_port #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) u_read_port_a (
        .clk          (clk),
        .rst          (rst),
        .read_enable  (read_enable_a),
        .read_address (read_address_a),
        .storage      (storage_q),
`ifdef REGFILE_WRITE_BYPASS_EN
        .write_enable (registerport_write_enable),
        .write_address(registerport_write_address),
        .write_data   (registerport_write_data),
`endif
        .read_data    (read_data_a),
        .read_valid   (read_valid_a)
    );

    register_file_read_port #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) u_read_port_b (
        .clk          (clk),
        .rst          (rst),
        .read_enable  (read_enable_b),
        .read_address (read_address_b),
        .storage      (storage_q),
`ifdef REGFILE_WRITE_BYPASS_EN
        .write_enable (registerport_write_enable),
        .write_address(registerport_write_address),
        .write_data   (registerport_write_data),
`endif
        .read_data    (read_data_b),
        .read_valid   (read_valid_b)
    );

endmodule

// File: tb/tb_register_file.sv
module tb_register_file;

    localparam int W  = 32;
    localparam int D  = 32;
    localparam int AW = $clog2(D);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          we = 1'b0;
    logic [AW-1:0] wa = '0;
    logic [W-1:0]  wd = '0;
    logic          rea = 1'b0, reb = 1'b0;
    logic [AW-1:0] raa = '0, rab = '0;
    logic [W-1:0]  rda, rdb;
    logic          rva, rvb;

    int vectors = 0;
    int miscompares = 0;

    logic [W-1:0] model [D];
    logic [W-1:0] q_a [$];
    logic [W-1:0] q_b [$];
    logic [W-1:0] last_a = '0, last_b = '0;

    always #5 clk = ~clk;

    register_file dut (
        .clk                       (clk),
        .rst                       (rst),
        .registerport_write_enable (we),
        .registerport_write_address(wa),
        .registerport_write_data   (wd),
        .read_enable_a             (rea),
        .read_address_a            (raa),
        .read_data_a               (rda),
        .read_valid_a              (rva),
        .read_enable_b             (reb),
        .read_address_b            (rab),
        .read_data_b               (rdb),
        .read_valid_b              (rvb)
    );

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] model_read(input int ra, input logic w_en,
                                                input int w_addr, input logic [W-1:0] w_data);
        if (ra == 0 || ra >= D) return '0;
`ifdef REGFILE_WRITE_BYPASS_EN
        if (w_en && w_addr == ra) return w_data;
`endif
        return model[ra];
    endfunction

    task automatic clear_model();
        for (int i = 0; i < D; i++) model[i] = '0;
        q_a.delete();
        q_b.delete();
        last_a = '0;
        last_b = '0;
    endtask

    // One clock of stimulus; expectations go into the per-port queues and
    // are popped when the port reports valid after the edge.
    task automatic step(input string tag, input logic w_en, input int w_addr,
                        input logic [W-1:0] w_data, input logic en_a, input int a_addr,
                        input logic en_b, input int b_addr);
        logic [W-1:0] exp;
        @(negedge clk);
        we  = w_en;  wa  = AW'(w_addr); wd = w_data;
        rea = en_a;  raa = AW'(a_addr);
        reb = en_b;  rab = AW'(b_addr);
        if (en_a) q_a.push_back(model_read(a_addr, w_en, w_addr, w_data));
        if (en_b) q_b.push_back(model_read(b_addr, w_en, w_addr, w_data));
        if (w_en && w_addr != 0 && w_addr < D) model[w_addr] = w_data;
        @(posedge clk);
        #1;
        if (en_a) begin
            exp = q_a.pop_front();
            last_a = exp;
            chk({tag, "_valid_a"}, W'(rva), W'(1));
        end else begin
            chk({tag, "_valid_a"}, W'(rva), W'(0));
        end
        chk({tag, "_data_a"}, rda, last_a);
        if (en_b) begin
            exp = q_b.pop_front();
            last_b = exp;
            chk({tag, "_valid_b"}, W'(rvb), W'(1));
        end else begin
            chk({tag, "_valid_b"}, W'(rvb), W'(0));
        end
        chk({tag, "_data_b"}, rdb, last_b);
    endtask

    initial begin
        clear_model();

        // Reset held from time 0.
        #12;
        chk("rst_data_a",  rda, '0);
        chk("rst_valid_a", W'(rva), '0);
        chk("rst_data_b",  rdb, '0);
        chk("rst_valid_b", W'(rvb), '0);
        @(negedge clk);
        rst = 1'b0;

        // All registers read 0 after reset.
        for (int i = 1; i < D; i++) step("init_read", 1'b0, 0, '0, 1'b1, i, 1'b1, D - i);

        // Write then read.
        step("wr_x5", 1'b1, 5, 32'hDEADBEEF, 1'b0, 0, 1'b0, 0);
        step("rd_x5", 1'b0, 0, '0, 1'b1, 5, 1'b0, 0);

        // x0 hardwired.
        step("wr_x0", 1'b1, 0, 32'hFFFFFFFF, 1'b0, 0, 1'b0, 0);
        step("rd_x0", 1'b0, 0, '0, 1'b1, 0, 1'b1, 0);

        // Same-cycle collision, then the following read sees the new value.
        step("wr_x7",      1'b1, 7, 32'h11111111, 1'b0, 0, 1'b0, 0);
        step("collide_x7", 1'b1, 7, 32'h22222222, 1'b1, 7, 1'b1, 7);
        step("after_x7",   1'b0, 0, '0, 1'b1, 7, 1'b0, 0);
        chk("after_x7_value", rda, 32'h22222222);

        // Collision with x0 never bypasses.
        step("collide_x0", 1'b1, 0, 32'hCAFEF00D, 1'b1, 0, 1'b0, 0);

        // Dual port then hold with valid low.
        step("wr_x3", 1'b1, 3, 32'h33, 1'b0, 0, 1'b0, 0);
        step("wr_x4", 1'b1, 4, 32'h44, 1'b0, 0, 1'b0, 0);
        step("rd_x3_x4", 1'b0, 0, '0, 1'b1, 3, 1'b1, 4);
        for (int i = 0; i < 3; i++) step("hold", 1'b0, 0, '0, 1'b0, 0, 1'b0, 0);
        chk("hold_value_a", rda, 32'h33);
        chk("hold_value_b", rdb, 32'h44);

        // Both ports on the same address.
        step("same_addr", 1'b0, 0, '0, 1'b1, 5, 1'b1, 5);

        // Asynchronous reset mid-cycle with results in flight.
        step("pre_rst", 1'b0, 0, '0, 1'b1, 5, 1'b1, 7);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_data_a",  rda, '0);
        chk("async_rst_valid_a", W'(rva), '0);
        chk("async_rst_data_b",  rdb, '0);
        chk("async_rst_valid_b", W'(rvb), '0);
        clear_model();
        @(negedge clk);
        rea = 1'b0; reb = 1'b0;
        rst = 1'b0;
        step("post_rst_x5", 1'b0, 0, '0, 1'b1, 5, 1'b1, 7);

        // Write coincident with reset assertion is not committed.
        @(negedge clk);
        we = 1'b1; wa = AW'(9); wd = 32'hABCD;
        #4;
        rst = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        we = 1'b0;
        rst = 1'b0;
        step("x9_dropped", 1'b0, 0, '0, 1'b1, 9, 1'b0, 0);
        step("wr_x9", 1'b1, 9, 32'hABCD, 1'b0, 0, 1'b0, 0);
        step("rd_x9", 1'b0, 0, '0, 1'b1, 9, 1'b1, 9);

        // Mixed random traffic against the model.
        for (int i = 0; i < 40; i++) begin
            step("rand", 1'($urandom), int'($urandom_range(0, D - 1)), W'($urandom),
                 1'($urandom), int'($urandom_range(0, D - 1)),
                 1'($urandom), int'($urandom_range(0, D - 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/register_file.md
Name: register_file

Overview:
- Responder end of the register write port driven by the writeback stage; also serves the decode stage's operand read ports.
- Holds DEPTH architectural registers of WIDTH bits.
- Provides two synchronous read ports (1-cycle latency) and one write port.
- Register x0 is hardwired to zero.

Parameters:
- WIDTH, REGISTER_WIDTH (32), bit width of each register and data bus.
- DEPTH, REGISTER_DEPTH (32), number of registers; address width is $clog2(DEPTH).

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- registerport_write.enable  input  1  write strobe (MemoryInterface, write-side modport).
- registerport_write.address  input  $clog2(DEPTH)  destination register.
- registerport_write.data  input  WIDTH  write data.
- read_enable_a  input  1  sample read port A this cycle.
- read_address_a  input  $clog2(DEPTH)  port A register index.
- read_data_a  output  WIDTH  port A result, registered.
- read_valid_a  output  1  read_data_a holds the result of a read sampled last cycle.
- read_enable_b, read_address_b, read_data_b, read_valid_b  as port A.

Behaviour:
- Reset (async, rst=1):
  - all storage registers clear to 0.
  - read_data_a/b = 0, read_valid_a/b = 0, immediately and independent of clk.
- Write:
  - At a clk edge with enable=1, storage[address] <= data.
  - A write to address 0 is discarded; x0 stays 0.
  - An address >= DEPTH (non-power-of-2 DEPTH) is discarded.
- Read, per port independently:
  - At a clk edge with read_enable=1, read_data <= storage[read_address] and read_valid <= 1.
  - Latency is exactly 1 cycle from address presentation.
- Read idle: with read_enable=0, read_data holds its previous value and read_valid <= 0.
- Address 0 always reads 0. An out-of-range address reads 0.
- Same-cycle write and read of the same nonzero address:
  - The result depends on REGFILE_WRITE_BYPASS_EN (see Optional Feature).
  - Storage always takes the new value.
- Both ports reading the same address in one cycle return identical data.
- No backpressure: the write port is always accepted. The writeback stage ties its tready high, consistent with this.
- Reset asserted mid-operation:
  - Any in-flight read result is lost; read_valid drops to 0 at once.
  - A write coincident with reset assertion is not committed.
- First edge after reset deassertion behaves normally.

Optional Feature:
- Macro: REGFILE_WRITE_BYPASS_EN.
- Defined: write-to-read bypass. When a read and a write target the same nonzero address in one cycle, read_data takes registerport_write.data (new value).
  - Writes to x0 are never bypassed; the read returns 0.
- Undefined: read-before-write. The read returns the old storage value.
  - The pipeline must then forward in the decode stage.

Decomposition:
- Shared package (existing core package) holds REGISTER_WIDTH, REGISTER_DEPTH and a typedef for the register address, logic [$clog2(REGISTER_DEPTH)-1:0].
- One sub-module: register_file_read_port, instantiated twice. It contains the registered read mux, the valid flag, and the bypass compare under the macro.
- Storage array and write logic stay in register_file.

Test Plan:
1. Reset values:
   - assert rst mid-cycle -> read_data_a/b = 0 and read_valid_a/b = 0 asynchronously.
   - after release, read x1..x31 -> all 0.
2. Write then read:
   - write x5 = 0xDEADBEEF; next cycle read A=x5 -> one cycle later read_data_a = 0xDEADBEEF, read_valid_a = 1.
3. x0 hardwired:
   - write x0 = 0xFFFFFFFF, then read A=x0, B=x0 -> both 0.
4. Same-cycle collision:
   - x7 = 0x11111111; in one cycle write x7 = 0x22222222 and read A=x7.
   - with macro -> read_data_a = 0x22222222; without -> 0x11111111.
   - either way, the following read returns 0x22222222.
5. Hold and dual port:
   - read A=x3 (0x33), B=x4 (0x44) -> 0x33 and 0x44.
   - then drop both read_enables for 3 cycles -> data holds 0x33/0x44, valid = 0.
6. Reset mid-operation:
   - write x9 = 0xABCD on the same edge rst rises -> after release, x9 reads 0.
